digital_word_to_bits: RTL and testbench
=======================================

# digital_word_to_bits

Receive-side deserializer of the 12-bit digital telemetry word link. It captures a 12-bit word on the rising edge of an externally supplied word strobe and unpacks payload bits 11 down to 1, MSB first, into a downstream bit buffer through a write/full handshake. It is the counterpart of the transmit-side packer that assembles words from a bit buffer and pads with zeros when that buffer is empty.

## Interface
- Parameters:
- POINTER_START, 11: index of the first payload bit emitted.
- POINTER_END, 1: index of the last payload bit emitted; bit 0 is don't-care and never emitted.
- Ports:
- clk  in  1  system clock, 240 MHz.
- reset  in  1  asynchronous, active-low.
- wordIn  in  12  received word; held stable for at least 3 clk cycles after wordStrobe rises.
- wordStrobe  in  1  word-valid strobe, asynchronous to clk; only its rising edge is significant.
- bitFull  in  1  bit buffer cannot accept a write.
- bitOut  out  1  bit being written.
- bitWrite  out  1  one-cycle write pulse; the sink stores bitOut at the end of that cycle.
- wordAck  out  1  one-cycle pulse when a word has been fully consumed.
- busy  out  1  high from capture until wordAck.
- overrun  out  1  sticky flag: a strobe edge arrived while the block was not IDLE.
- overrunClr  in  1  synchronous clear of overrun.

## Operation
- Strobe handling: wordStrobe passes through a 3-flop synchronizer (sync[2:0]). front = !sync[2] & sync[1].
- States are IDLE, LOAD, SHIFT, GAP.
- IDLE: on front, latch wordIn into the shift register, set pointer=POINTER_START and busy=1, then go to LOAD.
- LOAD: go to SHIFT. With the configuration macro compiled in, see Configuration.
- SHIFT: if bitFull=0, drive bitOut<=word[pointer] and bitWrite<=1, decrement pointer, and go to GAP. If bitFull=1, stay in SHIFT with bitWrite=0 and no limit on the stall.
- GAP: bitWrite<=0. If the bit just written was POINTER_END, drive wordAck<=1 and busy<=0 and go to IDLE. Otherwise go to SHIFT.
- Every bit occupies 2 cycles, so bitFull taken directly from the FIFO is always current when SHIFT samples it.
- Overrun: front in any state other than IDLE sets overrun=1 and drops the new word. The word in progress is unaffected.
- overrunClr clears the flag. If a set and a clear fall in the same cycle, set wins.
- Reset mid-word: all state clears immediately. The partial word is discarded, no wordAck is issued, and bits already written remain in the sink.
- Reset values: bitOut=0, bitWrite=0, wordAck=0, busy=0, overrun=0, sync=000, pointer=POINTER_START, state=IDLE.

## Timing
- wordStrobe rises before edge E0. front is high during E1–E2.
- E2: capture, LOAD, busy=1.
- E3: SHIFT.
- With no stall, bit k (k=0..10, bit index 11-k) is written with bitWrite high in cycle E(4+2k)–E(5+2k).
- E25: wordAck=1 and busy=0 for one cycle, state IDLE.
- Each stall cycle delays all later events by one cycle.
- Minimum strobe-edge spacing without overrun: 24 cycles. A front in the same cycle as the GAP→IDLE transition counts as an overrun.

## Configuration
- ZERO_WORD_DROP_EN:
- Defined: in LOAD, if word[11:1]==0, go straight to IDLE with wordAck=1, busy=0 at E3 and no bitWrite. This discards the transmitter's zero-fill idle words.
- Undefined: zero words are unpacked like any other word, producing 11 zero bits.

## Structure
- Package digital_link_pkg:
- state enum (IDLE, LOAD, SHIFT, GAP).
- WORD_W=12, POINTER_START=11, POINTER_END=1. The transmit-side packer shares these constants.
- Sub-module strobe_edge_sync: 3-flop synchronizer with rising-edge output. Async active-low reset to 0. Reused on the transmit side.

## Test plan
- wordIn=12'hA5A, single strobe, bitFull=0 -> bits 1,0,1,0,0,1,0,1,1,0,1 at E4,E6,…,E24; wordAck at E25; bit 0 never emitted.
- Same word with bitFull=1 for 5 cycles from E5 -> bit 1 delayed 5 cycles; wordAck at E30; no bit lost or duplicated.
- Second strobe 10 cycles after the first -> overrun=1, first word emitted intact, second absent. overrunClr -> 0.
- wordIn=12'h001 (payload zero): macro defined -> no bitWrite, wordAck at E3. Macro undefined -> 11 zero bits, wordAck at E25.
- reset low at E12 for 2 cycles -> all outputs 0 immediately; next strobe yields a complete fresh word.
- Back-to-back strobes 24 cycles apart with 12'hFFE, 12'h002 -> 22 bits in order, no overrun.

Source files
------------

// File: rtl/digital_link_pkg.sv
// Shared constants and FSM encoding for the 12-bit digital telemetry word link.
// Used by both the receive-side deserializer and the transmit-side packer.
package digital_link_pkg;

    localparam int WORD_W        = 12;
    localparam int POINTER_START = 11;
    localparam int POINTER_END   = 1;
    localparam int POINTER_W     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

endpackage

// File: rtl/digital_word_to_bits_strobe_edge_sync.sv
// Three-flop synchronizer for an asynchronous strobe with a one-cycle rising-edge output.
// Shared with the transmit-side packer.
module strobe_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic strobeIn,
    output logic front
);

    logic [2:0] sync;

    // Shift the asynchronous strobe through the synchronizer chain
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= 3'b000;
        end else begin
            sync <= {sync[1:0], strobeIn};
        end
    end

    assign front = !sync[2] & sync[1];

endmodule

// File: rtl/digital_word_to_bits.sv
// Receive-side deserializer: captures a word on the strobe edge and writes payload bits MSB first.
// Optional ZERO_WORD_DROP_EN: discard words whose payload bits are all zero without writing them.
module digital_word_to_bits
    import digital_link_pkg::*;
#(
    parameter int POINTER_START = digital_link_pkg::POINTER_START,
    parameter int POINTER_END   = digital_link_pkg::POINTER_END
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] wordIn,
    input  logic              wordStrobe,
    input  logic              bitFull,
    output logic              bitOut,
    output logic              bitWrite,
    output logic              wordAck,
    output logic              busy,
    output logic              overrun,
    input  logic              overrunClr
);

    localparam logic [POINTER_W-1:0] PTR_FIRST = POINTER_W'(POINTER_START);
    // Pointer value left behind once the last payload bit has been written
    localparam logic [POINTER_W-1:0] PTR_DONE  = POINTER_W'(POINTER_END - 1);

    logic                 front;
    state_t               state;
    logic [WORD_W-1:0]    shiftReg;
    logic [POINTER_W-1:0] pointer;

    strobe_edge_sync uStrobeSync (
        .clk      (clk),
        .reset    (reset),
        .strobeIn (wordStrobe),
        .front    (front)
    );

    // Sticky overrun flag; a new edge outside IDLE beats a simultaneous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (front && (state != IDLE)) begin
            overrun <= 1'b1;
        end else if (overrunClr) begin
            overrun <= 1'b0;
        end else begin
            overrun <= overrun;
        end
    end

    // Word capture and two-cycle-per-bit unpacking FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            shiftReg <= {WORD_W{1'b0}};
            pointer  <= PTR_FIRST;
            bitOut   <= 1'b0;
            bitWrite <= 1'b0;
            wordAck  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            bitWrite <= 1'b0;
            wordAck  <= 1'b0;
            case (state)
                IDLE: begin
                    if (front) begin
                        shiftReg <= wordIn;
                        pointer  <= PTR_FIRST;
                        busy     <= 1'b1;
                        state    <= LOAD;
                    end else begin
                        state    <= IDLE;
                    end
                end
                LOAD: begin
`ifdef ZERO_WORD_DROP_EN
                    if (shiftReg[WORD_W-1:1] == {(WORD_W-1){1'b0}}) begin
                        wordAck <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        state   <= SHIFT;
                    end
`else
                    state <= SHIFT;
`endif
                end
                SHIFT: begin
                    // A full sink stalls here indefinitely; nothing is written meanwhile
                    if (!bitFull) begin
                        bitOut   <= shiftReg[pointer];
                        bitWrite <= 1'b1;
                        pointer  <= pointer - 4'd1;
                        state    <= GAP;
                    end else begin
                        state    <= SHIFT;
                    end
                end
                GAP: begin
                    if (pointer == PTR_DONE) begin
                        wordAck <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        state   <= SHIFT;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digital_word_to_bits.sv
// Scoreboard bench for digital_word_to_bits: directed words, expected bits/acks queued with their cycles.
// Honours ZERO_WORD_DROP_EN for the payload-zero word expectation.
module tb_digital_word_to_bits;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] wordIn = 12'h000;
    logic        wordStrobe = 1'b0;
    logic        bitFull = 1'b0;
    logic        overrunClr = 1'b0;
    logic        bitOut, bitWrite, wordAck, busy, overrun;

    digital_word_to_bits dut (
        .clk        (clk),
        .reset      (reset),
        .wordIn     (wordIn),
        .wordStrobe (wordStrobe),
        .bitFull    (bitFull),
        .bitOut     (bitOut),
        .bitWrite   (bitWrite),
        .wordAck    (wordAck),
        .busy       (busy),
        .overrun    (overrun),
        .overrunClr (overrunClr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit   isAck;
        int   cycle;
        logic value;
    } exp_t;

    exp_t expQ[$];
    exp_t monE;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Strobe rises at cycle c: bit k is seen at cycle c+5+2k, ack at c+26; stall shifts bits after the first
    task automatic pushWord(input logic [11:0] w, input int c, input int stall, input int nBits);
        exp_t e;
        for (int k = 0; k < nBits; k++) begin
            e.isAck = 1'b0;
            e.cycle = c + 5 + 2 * k + ((k >= 1) ? stall : 0);
            e.value = w[11 - k];
            expQ.push_back(e);
        end
        if (nBits == 11) begin
            e.isAck = 1'b1;
            e.cycle = c + 26 + stall;
            e.value = 1'b0;
            expQ.push_back(e);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic sendWord(input logic [11:0] w, output int c);
        wordIn     = w;
        wordStrobe = 1'b1;
        c          = cyc;
        tick(4);
        wordStrobe = 1'b0;
    endtask

    task automatic drain();
        tick(40);
        check("queueDrained", expQ.size(), 0);
    endtask

    task automatic checkAllLow(input string tag);
        check({tag, "_bitOut"},   bitOut,   1'b0);
        check({tag, "_bitWrite"}, bitWrite, 1'b0);
        check({tag, "_wordAck"},  wordAck,  1'b0);
        check({tag, "_busy"},     busy,     1'b0);
        check({tag, "_overrun"},  overrun,  1'b0);
    endtask

    // Monitor: every write pulse or ack must match the next queued expectation
    always @(negedge clk) begin
        if (reset && (bitWrite || wordAck)) begin
            if (expQ.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected: bitWrite=%0b wordAck=%0b bitOut=%0b cycle %0d", bitWrite, wordAck, bitOut, cyc);
            end else begin
                monE = expQ.pop_front();
                check("eventKind", {31'd0, wordAck}, {31'd0, monE.isAck});
                check("eventCycle", cyc, monE.cycle);
                if (!monE.isAck) check("bitValue", {31'd0, bitOut}, {31'd0, monE.value});
            end
        end
    end

    initial begin
        int c, c2;
        tick(3);
        checkAllLow("reset");
        reset = 1'b1;
        tick(5);

        // Plain word
        sendWord(12'hA5A, c);
        pushWord(12'hA5A, c, 0, 11);
        check("busyDuringWord", busy, 1'b1);
        drain();
        check("busyAfterWord", busy, 1'b0);

        // Five stall cycles on the second bit
        sendWord(12'hA5A, c);
        pushWord(12'hA5A, c, 5, 11);
        tick(2);
        bitFull = 1'b1;
        tick(5);
        bitFull = 1'b0;
        drain();

        // Strobe 10 cycles after the first is dropped and flagged
        sendWord(12'hA5A, c);
        pushWord(12'hA5A, c, 0, 11);
        check("noOverrunYet", overrun, 1'b0);
        tick(6);
        sendWord(12'h3C3, c2);
        drain();
        check("overrunSet", overrun, 1'b1);
        overrunClr = 1'b1;
        tick(1);
        overrunClr = 1'b0;
        check("overrunCleared", overrun, 1'b0);

        // Payload-zero word
        sendWord(12'h001, c);
`ifdef ZERO_WORD_DROP_EN
        begin
            exp_t e;
            e.isAck = 1'b1;
            e.cycle = c + 4;
            e.value = 1'b0;
            expQ.push_back(e);
        end
`else
        pushWord(12'h001, c, 0, 11);
`endif
        drain();

        // Reset in the middle of a word, then a fresh word
        sendWord(12'hA5A, c);
        pushWord(12'hA5A, c, 0, 4);
        tick(8);
        reset = 1'b0;
        #1;
        checkAllLow("midReset");
        tick(2);
        reset = 1'b1;
        tick(3);
        sendWord(12'hA5A, c);
        pushWord(12'hA5A, c, 0, 11);
        drain();

        // Back-to-back words at the minimum spacing
        sendWord(12'hFFE, c);
        pushWord(12'hFFE, c, 0, 11);
        tick(20);
        sendWord(12'h002, c2);
        pushWord(12'h002, c2, 0, 11);
        drain();
        check("backToBackOverrun", overrun, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
